round_sched_ctrl: RTL

//   Sequences a best-of-ROUNDS reaction match: launches each game round, collects reaction times.

---
 rtl/round_sched_pkg.sv | 30 +++
 rtl/round_sched_ctrl_timer.sv | 27 ++
 rtl/round_sched_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/round_sched_pkg.sv
// Shared types and helpers for the reaction-match round scheduler.
package round_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_RES,
    ST_GAP,
    ST_SUMMARY
  } state_e;

  typedef enum logic [1:0] {
    DISP_LIVE = 2'd0,
    DISP_LAST = 2'd1,
    DISP_BEST = 2'd2,
    DISP_AVG  = 2'd3
  } disp_e;

  localparam logic [31:0] TIME_MAX = '1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/round_sched_ctrl_timer.sv
// Loadable down-counter shared by the result timeout and the inter-round gap.
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/round_sched_ctrl.sv
// Best-of-ROUNDS reaction match sequencer: launches rounds, records times, publishes summary.
// Optional feature: define AVERAGE_EN to keep a running sum and publish the mean time.
module round_sched_ctrl
  import round_sched_pkg::*;
#(
  parameter int unsigned ROUNDS      = 4,
  parameter int unsigned TIME_W      = 20,
  parameter int unsigned GAP_CYC     = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              round_done,
  input  logic              false_start,
  input  logic [TIME_W-1:0] round_time,
  output logic              round_start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        round_idx,
  output logic [TIME_W-1:0] last_time,
  output logic [TIME_W-1:0] best_time,
  output logic [TIME_W-1:0] avg_time,
  output logic [1:0]        disp_sel
);

  localparam int unsigned LOG2R   = clog2(ROUNDS);
  localparam int unsigned MAX_CYC = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = (clog2(MAX_CYC) < 1) ? 1 : clog2(MAX_CYC);
  localparam logic [TIME_W-1:0] T_MAX    = TIME_MAX[TIME_W-1:0];
  localparam logic [3:0]        LAST_IDX = 4'(ROUNDS - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  TO_LD    = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  disp_e             disp_q, disp_d;
  logic [3:0]        idx_q, idx_d;
  logic [TIME_W-1:0] last_q, last_d, best_q, best_d;
  logic              done_q, done_d, busy_q, busy_d, rs_q, rs_d;

  logic              tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]  tmr_ld_val;
  logic              rec, to_summary, start_match;
  logic [TIME_W-1:0] rec_val;

  assign start_match = (state_q == ST_IDLE) && start && !abort;

  cycle_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_ld_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    idx_d      = idx_q;
    last_d     = last_q;
    best_d     = best_q;
    done_d     = done_q;
    tmr_load   = 1'b0;
    tmr_ld_val = '0;
    tmr_dec    = 1'b0;
    rec        = 1'b0;
    rec_val    = '0;
    to_summary = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_match) begin
          state_d = ST_LAUNCH;
          idx_d   = '0;
          best_d  = T_MAX;
          done_d  = 1'b0;
        end
      end
      ST_LAUNCH: begin
        tmr_load   = 1'b1;
        tmr_ld_val = TO_LD;
        state_d    = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (round_done) begin
          rec     = 1'b1;
          rec_val = round_time;
        end else if (false_start || tmr_zero) begin
          rec     = 1'b1;
          rec_val = T_MAX;
        end else begin
          tmr_dec = 1'b1;
        end
        if (rec) begin
          last_d = rec_val;
          best_d = (rec_val < best_q) ? rec_val : best_q;
          if (idx_q == LAST_IDX) begin
            to_summary = 1'b1;
            state_d    = ST_SUMMARY;
          end else begin
            tmr_load   = 1'b1;
            tmr_ld_val = GAP_LD;
            state_d    = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_LAUNCH;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SUMMARY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
`ifdef AVERAGE_EN
          case (disp_q)
            DISP_LAST: disp_d = DISP_BEST;
            DISP_BEST: disp_d = DISP_AVG;
            default:   disp_d = DISP_LAST;
          endcase
`else
          disp_d = (disp_q == DISP_LAST) ? DISP_BEST : DISP_LAST;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (to_summary) begin
      done_d = 1'b1;
      disp_d = DISP_LAST;
    end

    // Abort in an active state discards this cycle's work but keeps recorded values.
    if (abort && (state_q inside {ST_LAUNCH, ST_WAIT_RES, ST_GAP})) begin
      state_d    = ST_IDLE;
      idx_d      = idx_q;
      last_d     = last_q;
      best_d     = best_q;
      done_d     = 1'b0;
      disp_d     = DISP_LIVE;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
      rec        = 1'b0;
      to_summary = 1'b0;
    end

    busy_d = state_d inside {ST_LAUNCH, ST_WAIT_RES, ST_GAP};
    rs_d   = (state_d == ST_LAUNCH);
    if (state_d inside {ST_LAUNCH, ST_WAIT_RES}) disp_d = DISP_LIVE;
    else if (state_d == ST_GAP)                  disp_d = DISP_LAST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      disp_q  <= DISP_LIVE;
      idx_q   <= '0;
      last_q  <= '0;
      best_q  <= T_MAX;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      best_q  <= best_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rs_q    <= rs_d;
    end
  end

`ifdef AVERAGE_EN
  localparam int unsigned SUM_W = TIME_W + LOG2R;

  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [TIME_W-1:0] avg_q, avg_d;

  always_comb begin
    sum_d = sum_q;
    avg_d = avg_q;
    if (start_match) sum_d = '0;
    else if (rec)    sum_d = sum_q + SUM_W'(rec_val);
    // The final round's value is folded in on the same edge the summary is published.
    if (to_summary)  avg_d = sum_d[SUM_W-1:LOG2R];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      avg_q <= '0;
    end else begin
      sum_q <= sum_d;
      avg_q <= avg_d;
    end
  end

  assign avg_time = avg_q;
`else
  assign avg_time = '0;
`endif

  assign round_start = rs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign round_idx   = idx_q;
  assign last_time   = last_q;
  assign best_time   = best_q;
  assign disp_sel    = disp_q;

endmodule
